// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller: shadows E/M/W destination tags, resolves youngest-producer
// forwarding selects for D/E/M operands, and interlocks HI/LO users against the MD unit.
module hazard_scoreboard_unit #(
    parameter int STAGES   = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [4:0]        D_Rs,
    input  logic [4:0]        D_Rt,
    input  logic [TNEW_W-1:0] D_Tuse_Rs,
    input  logic [TNEW_W-1:0] D_Tuse_Rt,
    input  logic [4:0]        D_A3,
    input  logic              D_RegWrite,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic              D_MDStart,
    input  logic              D_MDIsDiv,
    input  logic              D_MDUse,
    output logic              Stall,
    output logic [SEL_W-1:0]  D_FwdRs,
    output logic [SEL_W-1:0]  D_FwdRt,
    output logic [SEL_W-1:0]  E_FwdRs,
    output logic [SEL_W-1:0]  E_FwdRt,
    output logic [SEL_W-1:0]  M_FwdRt,
    output logic              MDBusy
);

    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    typedef struct packed {
        logic              valid;
        logic [4:0]        a3;
        logic [TNEW_W-1:0] tnew;
        logic              mdstart;
        logic              mddiv;
        logic [4:0]        rs;
        logic [4:0]        rt;
    } entry_t;

    typedef struct packed {
        logic              hit;
        logic [TNEW_W-1:0] tnew;
        logic [SEL_W-1:0]  sel;
    } match_t;

    entry_t           ent_q [STAGES];
    entry_t           ent_d [STAGES];
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    // Scanning oldest to youngest lets the lowest-k producer overwrite older (shadowed) ones.
    function automatic match_t youngest(input logic [4:0] src, input int lo);
        match_t m;
        m = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (k >= lo && ent_q[k].valid && ent_q[k].a3 == src && src != 5'd0) begin
                m.hit  = 1'b1;
                m.tnew = ent_q[k].tnew;
                m.sel  = SEL_W'(k + 1);
            end
        end
        return m;
    endfunction

    match_t m_d_rs, m_d_rt, m_e_rs, m_e_rt, m_m_rt;
    logic   stall_rs, stall_rt, stall_md;

    always_comb begin
        m_d_rs = youngest(D_Rs, 0);
        m_d_rt = youngest(D_Rt, 0);
        m_e_rs = youngest(ent_q[0].rs, 1);
        m_e_rt = youngest(ent_q[0].rt, 1);
        m_m_rt = youngest(ent_q[1].rt, 2);

        stall_rs = m_d_rs.hit && (m_d_rs.tnew > D_Tuse_Rs);
        stall_rt = m_d_rt.hit && (m_d_rt.tnew > D_Tuse_Rt);
        stall_md = D_MDUse && ((md_cnt_q != '0) || ent_q[0].mdstart);
        Stall    = !flush && (stall_rs || stall_rt || stall_md);

        D_FwdRs = (m_d_rs.hit && m_d_rs.tnew == '0) ? m_d_rs.sel : '0;
        D_FwdRt = (m_d_rt.hit && m_d_rt.tnew == '0) ? m_d_rt.sel : '0;
        E_FwdRs = (m_e_rs.hit && m_e_rs.tnew == '0) ? m_e_rs.sel : '0;
        E_FwdRt = (m_e_rt.hit && m_e_rt.tnew == '0) ? m_e_rt.sel : '0;
        M_FwdRt = (m_m_rt.hit && m_m_rt.tnew == '0) ? m_m_rt.sel : '0;
        MDBusy  = (md_cnt_q != '0);
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ent_d[k] = '0;
        end
        if (!Stall && !flush) begin
            ent_d[0].valid   = D_RegWrite && (D_A3 != 5'd0);
            ent_d[0].a3      = D_A3;
            ent_d[0].tnew    = D_Tnew;
            ent_d[0].mdstart = D_MDStart;
            ent_d[0].mddiv   = D_MDIsDiv;
            ent_d[0].rs      = D_Rs;
            ent_d[0].rt      = D_Rt;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (!flush) begin
                ent_d[k] = ent_q[k-1];
                if (ent_q[k-1].tnew != '0) begin
                    ent_d[k].tnew = ent_q[k-1].tnew - 1'b1;
                end
            end
        end

        md_cnt_d = md_cnt_q;
        if (flush) begin
            md_cnt_d = '0;
        end else if (ent_q[0].mdstart) begin
            md_cnt_d = ent_q[0].mddiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                ent_q[k] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                ent_q[k] <= ent_d[k];
            end
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: hand-derived stall/forward/MD-busy expectations.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic [4:0] D_Rs, D_Rt, D_A3;
    logic [1:0] D_Tuse_Rs, D_Tuse_Rt, D_Tnew;
    logic       D_RegWrite, D_MDStart, D_MDIsDiv, D_MDUse;
    logic       Stall, MDBusy;
    logic [1:0] D_FwdRs, D_FwdRt, E_FwdRs, E_FwdRt, M_FwdRt;

    int n_pass  = 0;
    int n_total = 0;

    hazard_scoreboard_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .D_Rs(D_Rs), .D_Rt(D_Rt), .D_Tuse_Rs(D_Tuse_Rs), .D_Tuse_Rt(D_Tuse_Rt),
        .D_A3(D_A3), .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew),
        .D_MDStart(D_MDStart), .D_MDIsDiv(D_MDIsDiv), .D_MDUse(D_MDUse),
        .Stall(Stall), .D_FwdRs(D_FwdRs), .D_FwdRt(D_FwdRt),
        .E_FwdRs(E_FwdRs), .E_FwdRt(E_FwdRt), .M_FwdRt(M_FwdRt), .MDBusy(MDBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
            $display("check %s: got %0d expected %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_d(input int rs, input int rt, input int urs, input int urt,
                         input int a3, input bit rw, input int tnew,
                         input bit mds, input bit mdd, input bit mdu);
        D_Rs = 5'(rs); D_Rt = 5'(rt); D_Tuse_Rs = 2'(urs); D_Tuse_Rt = 2'(urt);
        D_A3 = 5'(a3); D_RegWrite = rw; D_Tnew = 2'(tnew);
        D_MDStart = mds; D_MDIsDiv = mdd; D_MDUse = mdu;
        #1;
    endtask

    task automatic nop_d();
        set_d(0, 0, 3, 3, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop_d();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        nop_d();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_mdbusy", MDBusy, 0);
        chk("rst_dfwd", {D_FwdRs, D_FwdRt}, 0);
        chk("rst_efwd", {E_FwdRs, E_FwdRt, M_FwdRt}, 0);

        // lw $1 (Tnew 2) then addu $2,$1,$1 (Tuse 1)
        set_d(0, 0, 3, 3, 1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(1, 1, 1, 1, 2, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("lw_use_stall", Stall, 1);
        tick();
        chk("lw_use_nostall", Stall, 0);
        chk("lw_use_dfwd_rs", D_FwdRs, 0);
        chk("lw_use_efwd_rs_bubble", E_FwdRs, 0);
        chk("lw_use_efwd_rt_bubble", E_FwdRt, 0);
        tick();
        nop_d();
        chk("lw_use_efwd_rs_w", E_FwdRs, 3);
        chk("lw_use_efwd_rt_w", E_FwdRt, 3);
        drain();

        // lui $3 (Tnew 0) then beq $3,$0 (Tuse 0)
        set_d(0, 0, 3, 3, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(3, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("lui_beq_stall", Stall, 0);
        chk("lui_beq_dfwd_rs", D_FwdRs, 1);
        chk("lui_beq_dfwd_rt", D_FwdRt, 0);
        tick();
        drain();

        // ori $4, addu $4, subu $5,$4: youngest producer wins
        set_d(0, 0, 3, 3, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(0, 0, 3, 3, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(4, 0, 1, 1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("shadow_stall", Stall, 0);
        chk("shadow_dfwd_rs", D_FwdRs, 1);
        tick();
        nop_d();
        chk("shadow_efwd_rs", E_FwdRs, 2);
        drain();

        // addu $6 (Tnew 1) then sw $6 (Tuse rt 2)
        set_d(0, 0, 3, 3, 6, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(0, 6, 1, 2, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("sw_stall", Stall, 0);
        chk("sw_dfwd_rt", D_FwdRt, 0);
        tick();
        nop_d();
        chk("sw_efwd_rt", E_FwdRt, 2);
        tick();
        chk("sw_mfwd_rt", M_FwdRt, 3);
        drain();

        // mult then mflo: stall while mult in E, then 5 busy cycles
        set_d(7, 8, 1, 1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        tick();
        set_d(0, 0, 3, 3, 9, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        chk("mult_e_stall", Stall, 1);
        chk("mult_e_mdbusy", MDBusy, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mult_busy%0d_stall", i), Stall, 1);
            chk($sformatf("mult_busy%0d_mdbusy", i), MDBusy, 1);
            tick();
        end
        chk("mult_done_stall", Stall, 0);
        chk("mult_done_mdbusy", MDBusy, 0);
        tick();
        drain();

        // addu $0 then $0 reader
        set_d(0, 0, 3, 3, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(0, 0, 0, 0, 11, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("zero_stall", Stall, 0);
        chk("zero_dfwd", {D_FwdRs, D_FwdRt}, 0);
        tick();
        nop_d();
        chk("zero_efwd", {E_FwdRs, E_FwdRt}, 0);
        drain();

        // div busy for 10 cycles, then flush mid-count
        set_d(0, 0, 1, 1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        nop_d();
        tick();
        repeat (8) tick();
        set_d(0, 0, 3, 3, 10, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("div_busy_late", MDBusy, 1);
        tick();
        set_d(10, 10, 0, 0, 12, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        chk("div_prefl_stall", Stall, 1);
        flush = 1'b1;
        #1;
        chk("flush_stall_forced0", Stall, 0);
        tick();
        flush = 1'b0;
        set_d(10, 10, 0, 0, 12, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        chk("flush_mdbusy", MDBusy, 0);
        chk("flush_dfwd", {D_FwdRs, D_FwdRt}, 0);
        chk("flush_efwd", {E_FwdRs, E_FwdRt, M_FwdRt}, 0);
        chk("flush_stall", Stall, 0);
        drain();

        // reset mid-mult aborts the count
        set_d(0, 0, 1, 1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        tick();
        nop_d();
        tick();
        chk("rst_mid_busy", MDBusy, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mdbusy", MDBusy, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_after", MDBusy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
